// File: rtl/scan_pkg.sv
// Shared constants and types for the multiplexed digit scanner.
// Holds the state encoding, parameter defaults and the digit extraction helper.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int PRESCALE_DEFAULT     = 4;
    localparam int BLANK_CYCLES_DEFAULT = 1;

    function automatic logic [3:0] digit_of(input logic [63:0] data, input logic [3:0] idx);
        return data[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/decoder4_16.sv
// 4-to-16 one-hot decoder with an active-high enable; all outputs low when disabled.
module decoder4_16 (
    input  logic [3:0]  d,
    input  logic        en,
    output logic [15:0] o
);

    always_comb begin
        o = '0;
        if (en) o[d] = 1'b1;
    end

endmodule

// File: rtl/scan_ctrl.sv
// Time-multiplexed display scanner: each digit gets a blanking gap, then is shown
// for a fixed number of cycles, cycling through digits 0..last_digit.
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int PRESCALE     = PRESCALE_DEFAULT,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  last_digit,
    input  logic [63:0] data_in,
    output logic [3:0]  dec_sel,
    output logic        dec_en,
    output logic [15:0] digit_on,
    output logic [3:0]  nibble,
    output logic        frame_done
);

    // The timer holds remaining cycles minus one, so a phase ends when it reads zero.
    localparam logic [15:0] SHOW_LOAD  = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYCLES - 1);

    scan_state_t state, state_next;
    logic [15:0] timer, timer_next;
    logic [3:0]  idx, idx_next;
    logic        timer_done;
    logic        frame_end;
    logic        dec_en_next;
    logic        frame_done_next;
    logic        latch_nibble;

    assign timer_done = (timer == 16'd0);
    assign frame_end  = (state == SHOW) && timer_done && (idx >= last_digit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Dropping enable wins over every phase, so a partial frame never reports completion.
    always_comb begin
        state_next = state;
        timer_next = timer;
        idx_next   = idx;

        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = BLANK;
                BLANK:   if (timer_done) state_next = SHOW;
                SHOW:    if (timer_done) state_next = BLANK;
                default: state_next = IDLE;
            endcase
        end

        if (state_next == IDLE) begin
            idx_next   = 4'd0;
            timer_next = 16'd0;
        end else if (state_next != state) begin
            timer_next = (state_next == SHOW) ? SHOW_LOAD : BLANK_LOAD;
            if (state == SHOW) idx_next = frame_end ? 4'd0 : idx + 4'd1;
        end else begin
            timer_next = timer - 16'd1;
        end
    end

    always_comb begin
        dec_en_next     = (state_next == SHOW);
        frame_done_next = frame_end && (state_next == BLANK);
        latch_nibble    = (state == BLANK) && (state_next == SHOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= 16'd0;
            idx        <= 4'd0;
            dec_en     <= 1'b0;
            frame_done <= 1'b0;
            nibble     <= 4'd0;
        end else begin
            timer      <= timer_next;
            idx        <= idx_next;
            dec_en     <= dec_en_next;
            frame_done <= frame_done_next;
            if (latch_nibble) nibble <= digit_of(data_in, idx);
        end
    end

    assign dec_sel = idx;

    decoder4_16 u_decoder (
        .d  (dec_sel),
        .en (dec_en),
        .o  (digit_on)
    );

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl: expected digits are queued as stimulus is applied
// and popped as each blank/show interval is observed on the outputs.
module tb_scan_ctrl;

    localparam int PRE = 4;
    localparam int BLK = 2;
    localparam logic [63:0] DATA1 = 64'h0FED_CBA9_8765_4321;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  last_digit = 4'd0;
    logic [63:0] data_in = 64'd0;
    logic [3:0]  dec_sel;
    logic        dec_en;
    logic [15:0] digit_on;
    logic [3:0]  nibble;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fd = -1;
    int exp_period = 0;
    logic [63:0] saved_data;

    typedef enum int {ACT_NONE, ACT_SCRAMBLE, ACT_SET_LAST, ACT_DROP} act_t;
    typedef struct {
        logic [3:0] sel;
        logic [3:0] nib;
        logic       fb;
        int         show_len;
        act_t       act;
        logic [3:0] arg;
    } digit_t;

    digit_t exp_q[$];

    scan_ctrl #(.PRESCALE(PRE), .BLANK_CYCLES(BLK)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .last_digit (last_digit),
        .data_in    (data_in),
        .dec_sel    (dec_sel),
        .dec_en     (dec_en),
        .digit_on   (digit_on),
        .nibble     (nibble),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] ld, input logic [63:0] d);
        enable     = en;
        last_digit = ld;
        data_in    = d;
    endtask

    task automatic pushDigit(input int sel, input logic fb, input int show_len,
                             input act_t act, input logic [3:0] arg);
        digit_t e;
        e.sel      = 4'(sel);
        e.nib      = 4'((data_in >> (4 * sel)) & 64'hF);
        e.fb       = fb;
        e.show_len = show_len;
        e.act      = act;
        e.arg      = arg;
        exp_q.push_back(e);
    endtask

    task automatic notePulse();
        if (last_fd >= 0) checkOutput("frame_period", 64'(cyc - last_fd), 64'(exp_period));
        last_fd = cyc;
    endtask

    // Starts on the first blank sample of a digit; returns on the first sample after its show.
    task automatic observeDigit();
        digit_t e;
        int lows, highs, pulses;
        logic stable, onehot_ok, blank_ok;
        logic [3:0] nib0;
        if (exp_q.size() == 0) begin
            checkOutput("queue_empty", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        lows = 0; highs = 0; pulses = 0;
        stable = 1'b1; onehot_ok = 1'b1; blank_ok = 1'b1;
        checkOutput("frame_done_first_blank", 64'(frame_done), 64'(e.fb));
        while (!dec_en && lows < 50) begin
            if (frame_done) begin pulses++; notePulse(); end
            if (digit_on != 16'd0) blank_ok = 1'b0;
            lows++;
            step();
        end
        checkOutput("blank_len", 64'(lows), 64'(BLK));
        checkOutput("blank_digit_on", 64'(blank_ok), 64'd1);
        checkOutput("dec_sel", 64'(dec_sel), 64'(e.sel));
        checkOutput("nibble", 64'(nibble), 64'(e.nib));
        checkOutput("digit_on", 64'(digit_on), 64'(16'd1 << e.sel));
        nib0 = nibble;
        while (dec_en && highs < 50) begin
            if (frame_done) begin pulses++; notePulse(); end
            if (nibble != nib0 || dec_sel != e.sel) stable = 1'b0;
            if (digit_on != (16'd1 << e.sel)) onehot_ok = 1'b0;
            highs++;
            if (highs == 2) begin
                case (e.act)
                    ACT_SCRAMBLE: begin saved_data = data_in; data_in = ~data_in; end
                    ACT_SET_LAST: last_digit = e.arg;
                    ACT_DROP:     enable = 1'b0;
                    default: ;
                endcase
            end
            step();
        end
        if (e.act == ACT_SCRAMBLE) data_in = saved_data;
        checkOutput("show_len", 64'(highs), 64'(e.show_len));
        checkOutput("show_stable", 64'(stable), 64'd1);
        checkOutput("show_onehot", 64'(onehot_ok), 64'd1);
        checkOutput("frame_pulses", 64'(pulses), 64'(e.fb));
    endtask

    task automatic observeN(input int n);
        for (int i = 0; i < n; i++) observeDigit();
    endtask

    task automatic idleCheck(input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput("idle_dec_en", 64'(dec_en), 64'd0);
            checkOutput("idle_frame_done", 64'(frame_done), 64'd0);
            checkOutput("idle_digit_on", 64'(digit_on), 64'd0);
            step();
        end
    endtask

    task automatic resetValues(input string tag);
        checkOutput({tag, "_dec_sel"}, 64'(dec_sel), 64'd0);
        checkOutput({tag, "_dec_en"}, 64'(dec_en), 64'd0);
        checkOutput({tag, "_nibble"}, 64'(nibble), 64'd0);
        checkOutput({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        checkOutput({tag, "_digit_on"}, 64'(digit_on), 64'd0);
    endtask

    initial begin
        step();
        resetValues("reset");
        rst = 1'b0;
        step();
        idleCheck(2);

        // Basic four-digit scan, with data disturbed mid-show in the second frame.
        applyStimulus(1'b1, 4'd3, DATA1);
        last_fd = -1; exp_period = 24;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++)
                pushDigit(i, (f > 0 && i == 0), PRE, (f == 1 && i == 1) ? ACT_SCRAMBLE : ACT_NONE, 4'd0);
        pushDigit(0, 1'b1, PRE, ACT_NONE, 4'd0);
        checkOutput("nibble_digit0_model", 64'(exp_q[0].nib), 64'd1);
        step();
        observeN(9);
        enable = 1'b0;
        step();
        idleCheck(3);

        // Full sixteen-digit scan wrapping 15 -> 0.
        applyStimulus(1'b1, 4'd15, DATA1);
        last_fd = -1; exp_period = 96;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++)
                pushDigit(i, (f > 0 && i == 0), PRE, ACT_NONE, 4'd0);
        pushDigit(0, 1'b1, PRE, ACT_NONE, 4'd0);
        step();
        observeN(33);
        enable = 1'b0;
        step();
        idleCheck(3);

        // Shrinking last_digit during digit 2 lets digit 2 finish, then wraps.
        applyStimulus(1'b1, 4'd7, DATA1);
        last_fd = -1; exp_period = 12;
        pushDigit(0, 1'b0, PRE, ACT_NONE, 4'd0);
        pushDigit(1, 1'b0, PRE, ACT_NONE, 4'd0);
        pushDigit(2, 1'b0, PRE, ACT_SET_LAST, 4'd1);
        pushDigit(0, 1'b1, PRE, ACT_NONE, 4'd0);
        pushDigit(1, 1'b0, PRE, ACT_NONE, 4'd0);
        pushDigit(0, 1'b1, PRE, ACT_NONE, 4'd0);
        step();
        observeN(6);
        enable = 1'b0;
        step();
        idleCheck(3);

        // Disable during digit 1, then restart from digit 0.
        applyStimulus(1'b1, 4'd3, DATA1);
        last_fd = -1;
        pushDigit(0, 1'b0, PRE, ACT_NONE, 4'd0);
        pushDigit(1, 1'b0, 2, ACT_DROP, 4'd0);
        step();
        observeN(2);
        idleCheck(4);
        applyStimulus(1'b1, 4'd3, DATA1);
        pushDigit(0, 1'b0, PRE, ACT_NONE, 4'd0);
        pushDigit(1, 1'b0, PRE, ACT_NONE, 4'd0);
        step();
        observeN(2);

        // Asynchronous reset between edges while a digit is shown.
        for (int i = 0; i < 50 && !dec_en; i++) step();
        checkOutput("pre_reset_show", 64'(dec_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_dec_en", 64'(dec_en), 64'd0);
        checkOutput("async_digit_on", 64'(digit_on), 64'd0);
        step();
        resetValues("hold1");
        step();
        resetValues("hold2");
        rst = 1'b0;
        pushDigit(0, 1'b0, PRE, ACT_NONE, 4'd0);
        pushDigit(1, 1'b0, PRE, ACT_NONE, 4'd0);
        step();
        observeN(2);

        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4: clock cycles each digit is shown (dec_en high); legal range 1..65535.
REQ-002 Parameter BLANK_CYCLES, default 1: clock cycles of blanking (dec_en low) before each digit; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  scanning runs while high and stops while low.
REQ-006 last_digit  input  4  index of the highest digit in the scan (0..15).
REQ-007 data_in  input  64  sixteen 4-bit digit values; digit i = data_in[4i+3:4i].
REQ-008 dec_sel  output  4  select code driven to the 4-to-16 decoder.
REQ-009 dec_en  output  1  decoder enable; high only while a digit is shown.
REQ-010 digit_on  output  16  one-hot digit strobe (decoded dec_sel gated by dec_en).
REQ-011 nibble  output  4  value of the digit currently shown.
REQ-012 frame_done  output  1  one-cycle pulse after the last digit of a frame has been shown.

Function
REQ-013 The block SHALL implement three states: IDLE, BLANK and SHOW.
REQ-014 IDLE: dec_en=0; when enable=1, the block SHALL load idx=0 and timer=0, then move to BLANK on the next cycle.
REQ-015 BLANK: dec_sel=idx and dec_en=0 for exactly BLANK_CYCLES cycles, then move to SHOW.
REQ-016 On entry to SHOW, nibble SHALL latch data_in[4*idx+3:4*idx]; nibble stays stable for the whole SHOW interval even if data_in changes.
REQ-017 SHOW: dec_en=1 for exactly PRESCALE cycles, then move to BLANK.
REQ-018 idx update at the end of SHOW: if idx >= last_digit (sampled on that cycle), idx becomes 0 and frame_done pulses for one cycle (the first cycle of the next BLANK); otherwise idx becomes idx+1.
REQ-019 With last_digit=15, idx SHALL wrap from 15 to 0; idx is never out of range.
REQ-020 A last_digit change mid-frame SHALL take effect at the next end-of-SHOW check only; it does not cut the current digit short.
REQ-021 enable=0 in any state: the next state is IDLE and dec_en=0 from the next cycle; frame_done is not pulsed.
REQ-022 A re-enable always restarts from idx=0 with BLANK first.
REQ-023 Digit period SHALL be BLANK_CYCLES+PRESCALE cycles; frame period is (last_digit+1)*(BLANK_CYCLES+PRESCALE) cycles.
REQ-024 digit_on SHALL be all zeros whenever dec_en=0; otherwise its bit dec_sel is 1 and all other bits are 0.
REQ-025 All outputs except digit_on SHALL be registered; the timer is 16 bits wide and counts down to zero, with no overflow at any legal parameter value.

Reset
REQ-026 While rst=1, regardless of clk: state=IDLE, idx=0, timer=0, dec_sel=0, dec_en=0, nibble=0, frame_done=0; as a result digit_on=0.
REQ-027 rst asserted mid-SHOW SHALL drop dec_en immediately (asynchronously); after release, the scan restarts per REQ-014 if enable=1.

Structure
REQ-028 State encodings (IDLE=2'd0, BLANK=2'd1, SHOW=2'd2) and the PRESCALE and BLANK_CYCLES defaults SHALL live in the shared scan_pkg constants file.
REQ-029 digit_on SHALL be produced by one instance of the existing decoder4_16 (d=dec_sel, en=dec_en, o=digit_on); there are no other sub-modules.

Verification (PRESCALE=4, BLANK_CYCLES=2)
REQ-030 Reset then enable=1, last_digit=3 -> dec_en low for 2 cycles and high for 4 cycles per digit; dec_sel runs 0,1,2,3,0; frame_done pulses once every 24 cycles.
REQ-031 data_in=64'h...._4321, last_digit=3 -> nibble equals 1,2,3,4 during SHOW of digits 0..3; digit_on equals 0001, 0002, 0004, 0008 (hex).
REQ-032 last_digit=15 -> idx wraps 15 to 0; digit_on reaches 16'h8000; frame period is 96 cycles.
REQ-033 During SHOW of digit 2, change last_digit from 7 to 1 -> digit 2 completes, then idx goes to 0 with a frame_done pulse.
REQ-034 enable=0 during SHOW of digit 1 -> dec_en is 0 on the next cycle and stays in IDLE with no frame_done; after enable=1 the scan restarts at digit 0 after 2 blank cycles.
REQ-035 rst pulse between clock edges mid-SHOW -> dec_en and digit_on go to 0 immediately, and all outputs hold their reset values until rst is released.
